// File: rtl/uart_tx_fifo_engine_pkg.sv
// Shared UART transmit constants: parity encodings, serializer states, baud floor.
package uart_tx_fifo_engine_pkg;

   localparam logic [1:0]  PAR_NONE = 2'b00;
   localparam logic [1:0]  PAR_ODD  = 2'b01;
   localparam logic [1:0]  PAR_EVEN = 2'b10;

   localparam logic [19:0] BAUD_MIN = 20'd4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_t;

   function automatic logic [19:0] clamp_baud(input logic [19:0] baud);
      return (baud < BAUD_MIN) ? BAUD_MIN : baud;
   endfunction

   // Even parity makes the total count of ones even; odd is its inverse.
   function automatic logic parity_bit(input logic [7:0] dat, input logic [1:0] sel);
      logic bit_val;
      case (sel)
         PAR_EVEN: bit_val = ^dat;
         PAR_ODD:  bit_val = ~^dat;
         PAR_NONE: bit_val = 1'b0;
         default:  bit_val = 1'b0;
      endcase
      return bit_val;
   endfunction

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO with show-ahead read data and an occupancy counter for flags/level.
// Push visible to the reader one cycle later; pop data is valid combinationally.
// Pushes while full are dropped, pops while empty are ignored.
module uart_tx_byte_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [7:0]         push_dat,
   input  logic               pop,
   output logic [7:0]         pop_dat,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   level
);

   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

   logic [7:0]         mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign level   = count;
   assign pop_dat = mem[rd_ptr];

   // A full buffer rejects the push even when a pop frees a slot this cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// Buffered UART transmitter: byte FIFO feeding a start/8N/parity/stop serializer.
// Start bit appears three cycles after a write into an idle, empty block.
// Writes are dropped while Full_sig is high; frames run back-to-back while data is queued.
module uart_tx_fifo_engine
   import uart_tx_fifo_engine_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               WR_Req_sig,
   input  logic [7:0]         FIFO_WR_Dat,
   input  logic [19:0]        BaudRate,
   input  logic [1:0]         FrameCheck,
   output logic               TX_pin,
   output logic               Full_sig,
   output logic               Empty_sig,
   output logic               Busy_sig,
   output logic [FIFO_AW:0]   Level
);

   tx_state_t        state;
   logic             tx_q;
   logic             busy_q;
   logic [19:0]      bit_cnt;
   logic [19:0]      baud_lat;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic             par_en;
   logic             par_val;

   logic             fifo_pop;
   logic [7:0]       fifo_dat;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FIFO_AW:0] fifo_level;

   logic             bit_done;
   logic [19:0]      baud_nxt;
   logic             par_en_nxt;
   logic             par_val_nxt;

   uart_tx_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RSTn),
      .push     (WR_Req_sig),
      .push_dat (FIFO_WR_Dat),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   assign Full_sig  = fifo_full;
   assign Empty_sig = fifo_empty;
   assign Level     = fifo_level;
   assign TX_pin    = tx_q;
   assign Busy_sig  = busy_q;

   assign bit_done = (bit_cnt == '0);

   // The byte is taken on the same edge that enters LOAD, from IDLE or the end of STOP.
   assign fifo_pop    = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
   assign baud_nxt    = clamp_baud(BaudRate);
   assign par_en_nxt  = (FrameCheck == PAR_ODD) || (FrameCheck == PAR_EVEN);
   assign par_val_nxt = parity_bit(fifo_dat, FrameCheck);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state    <= IDLE;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         bit_cnt  <= '0;
         baud_lat <= '0;
         shreg    <= '0;
         bit_idx  <= '0;
         par_en   <= 1'b0;
         par_val  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_q <= 1'b1;
               if (fifo_pop) begin
                  state    <= LOAD;
                  busy_q   <= 1'b1;
                  shreg    <= fifo_dat;
                  baud_lat <= baud_nxt;
                  par_en   <= par_en_nxt;
                  par_val  <= par_val_nxt;
               end
            end
            LOAD: begin
               state   <= START;
               tx_q    <= 1'b0;
               bit_cnt <= baud_lat - 20'd1;
            end
            START: begin
               if (bit_done) begin
                  state   <= DATA;
                  tx_q    <= shreg[0];
                  bit_idx <= '0;
                  bit_cnt <= baud_lat - 20'd1;
               end else begin
                  bit_cnt <= bit_cnt - 20'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  bit_cnt <= baud_lat - 20'd1;
                  if (bit_idx == 3'd7) begin
                     if (par_en) begin
                        state <= PARITY;
                        tx_q  <= par_val;
                     end else begin
                        state <= STOP;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[1];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  bit_cnt <= bit_cnt - 20'd1;
               end
            end
            PARITY: begin
               if (bit_done) begin
                  state   <= STOP;
                  tx_q    <= 1'b1;
                  bit_cnt <= baud_lat - 20'd1;
               end else begin
                  bit_cnt <= bit_cnt - 20'd1;
               end
            end
            STOP: begin
               tx_q <= 1'b1;
               if (bit_done) begin
                  if (fifo_pop) begin
                     state    <= LOAD;
                     shreg    <= fifo_dat;
                     baud_lat <= baud_nxt;
                     par_en   <= par_en_nxt;
                     par_val  <= par_val_nxt;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 20'd1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Directed and randomized frame checks against a bit-list model of the UART line.
module tb_uart_tx_fifo_engine;

   logic        CLK;
   logic        RSTn;
   logic        WR_Req_sig;
   logic [7:0]  FIFO_WR_Dat;
   logic [19:0] BaudRate;
   logic [1:0]  FrameCheck;
   logic        TX_pin;
   logic        Full_sig;
   logic        Empty_sig;
   logic        Busy_sig;
   logic [4:0]  Level;

   int checks   = 0;
   int failures = 0;

   uart_tx_fifo_engine #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .WR_Req_sig  (WR_Req_sig),
      .FIFO_WR_Dat (FIFO_WR_Dat),
      .BaudRate    (BaudRate),
      .FrameCheck  (FrameCheck),
      .TX_pin      (TX_pin),
      .Full_sig    (Full_sig),
      .Empty_sig   (Empty_sig),
      .Busy_sig    (Busy_sig),
      .Level       (Level)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      WR_Req_sig  = 1'b1;
      FIFO_WR_Dat = d;
      @(negedge CLK);
      WR_Req_sig  = 1'b0;
   endtask

   // Returns at the first negedge sample showing TX_pin low, counting high samples before it.
   task automatic wait_start(input int limit, output int highs, output bit found);
      highs = 0;
      found = 1'b0;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge CLK);
         if (TX_pin === 1'b0) found = 1'b1;
         else highs++;
      end
   endtask

   // Model: start 0, eight data bits LSB first, optional parity, stop 1; each bit max(baud,4) cycles.
   // Called at the first sample of the start bit; returns at the last sample of the stop bit.
   task automatic expect_frame(input logic [7:0] b, input logic [1:0] fc, input int baud, input string tag);
      logic bits[$];
      int   eff, ones, bad;
      eff  = (baud < 4) ? 4 : baud;
      ones = $countones(b);
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (fc == 2'b10) bits.push_back((ones % 2) == 1);
      else if (fc == 2'b01) bits.push_back((ones % 2) == 0);
      bits.push_back(1'b1);
      for (int i = 0; i < bits.size(); i++) begin
         bad = 0;
         for (int c = 0; c < eff; c++) begin
            if (i != 0 || c != 0) @(negedge CLK);
            if (TX_pin !== bits[i]) bad++;
         end
         chk($sformatf("%s_bit%0d", tag, i), bad, 0);
      end
   endtask

   initial begin
      int          h;
      bit          f;
      logic [7:0]  a, b, q;
      logic [7:0]  dq [17];
      logic [7:0]  bq [5];
      logic [1:0]  fc;
      int          baud, n;

      RSTn        = 1'b0;
      WR_Req_sig  = 1'b0;
      FIFO_WR_Dat = 8'h00;
      BaudRate    = 20'd434;
      FrameCheck  = 2'b00;

      #12;
      chk("rst_tx", TX_pin, 1);
      chk("rst_busy", Busy_sig, 0);
      chk("rst_full", Full_sig, 0);
      chk("rst_empty", Empty_sig, 1);
      chk("rst_level", Level, 0);
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);

      // 0x55 at 434 cycles per bit, no parity, with start-bit latency.
      push_byte(8'h55);
      chk("t039_level1", Level, 1);
      chk("t039_empty0", Empty_sig, 0);
      wait_start(10, h, f);
      chk("t039_found", f, 1);
      chk("t039_latency", h, 1);
      chk("t039_busy", Busy_sig, 1);
      expect_frame(8'h55, 2'b00, 434, "t039");
      @(negedge CLK);
      chk("t039_busy_end", Busy_sig, 0);
      chk("t039_idle_tx", TX_pin, 1);
      chk("t039_empty_end", Empty_sig, 1);

      // Parity of 0x03: even and odd, 11-bit frames.
      BaudRate = 20'd10;
      FrameCheck = 2'b10;
      push_byte(8'h03);
      wait_start(10, h, f);
      chk("t040e_latency", h, 1);
      expect_frame(8'h03, 2'b10, 10, "t040e");
      @(negedge CLK);
      chk("t040e_busy_end", Busy_sig, 0);
      FrameCheck = 2'b01;
      push_byte(8'h03);
      wait_start(10, h, f);
      chk("t040o_latency", h, 1);
      expect_frame(8'h03, 2'b01, 10, "t040o");
      @(negedge CLK);
      chk("t040o_busy_end", Busy_sig, 0);

      // BaudRate below the floor.
      BaudRate = 20'd1;
      FrameCheck = 2'b00;
      push_byte(8'hA0);
      wait_start(10, h, f);
      chk("t044_found", f, 1);
      expect_frame(8'hA0, 2'b00, 1, "t044");
      @(negedge CLK);
      chk("t044_busy_end", Busy_sig, 0);

      // BaudRate change during a frame only affects the next frame.
      BaudRate = 20'd10;
      a = 8'($urandom);
      b = 8'($urandom);
      push_byte(a);
      push_byte(b);
      wait_start(10, h, f);
      chk("t042_found", f, 1);
      BaudRate = 20'd20;
      expect_frame(a, 2'b00, 10, "t042a");
      wait_start(5, h, f);
      chk("t042_gap", h, 1);
      expect_frame(b, 2'b00, 20, "t042b");
      @(negedge CLK);
      chk("t042_busy_end", Busy_sig, 0);

      // Overfill during a frame: 17 writes, 16 kept and sent back-to-back.
      BaudRate = 20'd4;
      FrameCheck = 2'b00;
      push_byte(8'hFF);
      wait_start(10, h, f);
      chk("t041_found0", f, 1);
      fc = 2'($urandom);
      FrameCheck = fc;
      for (int j = 0; j < 17; j++) dq[j] = 8'($urandom);
      for (int j = 0; j < 17; j++) begin
         if (j == 16) begin
            chk("t041_level16", Level, 16);
            chk("t041_full", Full_sig, 1);
         end
         push_byte(dq[j]);
      end
      chk("t041_level_drop", Level, 16);
      chk("t041_full_drop", Full_sig, 1);
      wait_start(100, h, f);
      chk("t041_found1", f, 1);
      expect_frame(dq[0], fc, 4, "t041_0");
      for (int j = 1; j < 16; j++) begin
         wait_start(5, h, f);
         chk($sformatf("t041_gap%0d", j), h, 1);
         expect_frame(dq[j], fc, 4, $sformatf("t041_%0d", j));
      end
      wait_start(200, h, f);
      chk("t041_no17th", f, 0);
      chk("t041_busy_end", Busy_sig, 0);
      chk("t041_empty_end", Empty_sig, 1);

      // Reset during data bit 3 with 5 bytes queued.
      BaudRate = 20'd10;
      FrameCheck = 2'b00;
      q = 8'($urandom) & 8'hF7;
      push_byte(q);
      for (int j = 0; j < 5; j++) push_byte(8'($urandom));
      repeat (42) @(negedge CLK);
      chk("t043_pre_bit3", TX_pin, 0);
      chk("t043_pre_level", Level, 5);
      RSTn = 1'b0;
      #1;
      chk("t043_tx", TX_pin, 1);
      chk("t043_busy", Busy_sig, 0);
      chk("t043_empty", Empty_sig, 1);
      chk("t043_level", Level, 0);
      chk("t043_full", Full_sig, 0);
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      wait_start(300, h, f);
      chk("t043_silent", f, 0);
      a = 8'($urandom);
      push_byte(a);
      wait_start(10, h, f);
      chk("t043_new_latency", h, 1);
      expect_frame(a, 2'b00, 10, "t043_new");
      @(negedge CLK);
      chk("t043_busy_end", Busy_sig, 0);

      // Randomized bursts with random baud and parity.
      for (int it = 0; it < 4; it++) begin
         baud = $urandom_range(1, 8);
         fc   = 2'($urandom);
         n    = $urandom_range(1, 5);
         BaudRate   = 20'(baud);
         FrameCheck = fc;
         for (int j = 0; j < n; j++) bq[j] = 8'($urandom);
         fork
            begin
               for (int j = 0; j < n; j++) push_byte(bq[j]);
            end
            begin
               int  hh;
               bit  ff;
               wait_start(20, hh, ff);
               chk($sformatf("rnd%0d_latency", it), hh, 2);
               expect_frame(bq[0], fc, baud, $sformatf("rnd%0d_0", it));
            end
         join
         for (int j = 1; j < n; j++) begin
            wait_start(5, h, f);
            chk($sformatf("rnd%0d_gap%0d", it, j), h, 1);
            expect_frame(bq[j], fc, baud, $sformatf("rnd%0d_%0d", it, j));
         end
         @(negedge CLK);
         chk($sformatf("rnd%0d_busy_end", it), Busy_sig, 0);
         chk($sformatf("rnd%0d_empty_end", it), Empty_sig, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_engine.md
UART_TX_FIFO_ENGINE -- requirements
Module: uart_tx_fifo_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of byte entries in the transmit buffer (power of two, 4..256).
REQ-002 SHALL have parameter FIFO_AW, default 4, equal to log2(FIFO_DEPTH).
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port WR_Req_sig  input  1  push FIFO_WR_Dat into buffer this cycle.
REQ-006 SHALL have port FIFO_WR_Dat  input  8  byte to transmit.
REQ-007 SHALL have port BaudRate  input  20  CLK cycles per UART bit.
REQ-008 SHALL have port FrameCheck  input  2  parity select: 00 none, 01 odd, 10 even, 11 none.
REQ-009 SHALL have port TX_pin  output  1  serial line, idle high.
REQ-010 SHALL have port Full_sig  output  1  buffer full.
REQ-011 SHALL have port Empty_sig  output  1  buffer empty.
REQ-012 SHALL have port Busy_sig  output  1  frame in progress on TX_pin.
REQ-013 SHALL have port Level  output  FIFO_AW+1  current buffer occupancy.

Function
REQ-014 SHALL buffer bytes in a synchronous FIFO, with write on WR_Req_sig=1 and Full_sig=0.
REQ-015 SHALL drop a write while Full_sig=1, even if a pop occurs the same cycle, leaving contents and Level unchanged.
REQ-016 SHALL, on simultaneous push and pop with 0<Level<FIFO_DEPTH, leave Level unchanged and preserve order.
REQ-017 SHALL never pop while Empty_sig=1; a push into an empty buffer becomes poppable the next cycle.
REQ-018 SHALL use states IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-019 SHALL move IDLE->LOAD when Empty_sig=0: pop one byte; latch byte, BaudRate and FrameCheck.
REQ-020 SHALL move LOAD->START on the next cycle, driving TX_pin=0.
REQ-021 SHALL move START->DATA after one bit period.
REQ-022 SHALL shift 8 data bits LSB first in DATA, one bit period each.
REQ-023 SHALL move DATA->PARITY after bit 7 if latched FrameCheck is 01 or 10; otherwise DATA->STOP.
REQ-024 SHALL, in PARITY, drive XOR of data bits for even (10) and its inverse for odd (01), for one bit period.
REQ-025 SHALL drive TX_pin=1 for one bit period in STOP.
REQ-026 SHALL, at the end of STOP, move to LOAD if Empty_sig=0 (back-to-back frames, no idle gap), else to IDLE.
REQ-027 SHALL make a bit period exactly the latched BaudRate cycles, counted by a 20-bit down-counter.
REQ-028 SHALL treat latched BaudRate values below 4 as 4.
REQ-029 SHALL ignore changes to BaudRate and FrameCheck until the next LOAD.
REQ-030 SHALL have latency such that a write at cycle n into an empty, idle block drives the start bit on TX_pin from cycle n+3.
REQ-031 SHALL assert Busy_sig in LOAD, START, DATA, PARITY and STOP, and deassert it in IDLE only.
REQ-032 SHALL register TX_pin so it is glitch-free, and drive it high in IDLE and LOAD.
REQ-033 SHALL derive Full_sig, Empty_sig and Level from a FIFO_AW+1-bit occupancy counter; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 SHALL, while RSTn=0, immediately force TX_pin=1, Busy_sig=0, Full_sig=0, Empty_sig=1, Level=0, state IDLE, and all pointers and counters to 0.
REQ-035 SHALL, on reset mid-frame, abandon the frame and discard buffered bytes; no partial frame SHALL resume after release.
REQ-036 SHALL leave FIFO storage RAM uninitialised at reset, since it is unobservable.

Structure
REQ-037 SHALL place the parity encodings (NONE/ODD/EVEN), state encodings and the BaudRate minimum (4) in the shared UART constants include file.
REQ-038 SHALL implement the buffer as one sub-module, uart_tx_byte_fifo (parameters FIFO_DEPTH and FIFO_AW), and the serializer FSM in the top.

Verification
REQ-039 SHALL verify: BaudRate=434, FrameCheck=00, write 0x55 -> TX_pin 0,1,0,1,0,1,0,1,0,1 with each bit exactly 434 cycles, then idle high, Busy_sig low after 4340 cycles.
REQ-040 SHALL verify: BaudRate=10, FrameCheck=10, write 0x03 -> parity bit 0; with FrameCheck=01 -> parity bit 1; frame is 11 bits.
REQ-041 SHALL verify: 17 writes on consecutive cycles while a frame is in progress -> Full_sig=1 at Level 16, 17th byte absent from output, remaining 16 bytes sent back-to-back with no gap between frames.
REQ-042 SHALL verify: BaudRate changed from 10 to 20 mid-frame -> current frame keeps 10-cycle bits and the next frame uses 20-cycle bits.
REQ-043 SHALL verify: RSTn pulsed low during DATA bit 3 with 5 bytes queued -> TX_pin=1 within the same cycle, Empty_sig=1, and no output after release until a new write.
REQ-044 SHALL verify: BaudRate=1 with a write of 0xA0 -> every bit lasts 4 cycles.
